// File: rtl/change_decoder_pkg.sv
// Shared code values, state encodings and decode helpers for the change-hint receiver.
package change_decoder_pkg;

  localparam logic [3:0] CODE_IDLE  = 4'b1110;
  localparam logic [3:0] CODE_BLINK = 4'b1111;
  localparam int         HINT_BITS  = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_SOLVED = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CL_IDX     = 2'd0,
    CL_BLINK   = 2'd1,
    CL_IDLE    = 2'd2,
    CL_ILLEGAL = 2'd3
  } code_class_e;

  function automatic code_class_e classify(input logic [3:0] code, input int num_bits);
    code_class_e cls;
    if (code == CODE_BLINK) begin
      cls = CL_BLINK;
    end else if (code == CODE_IDLE) begin
      cls = CL_IDLE;
    end else if (int'(code) < num_bits) begin
      cls = CL_IDX;
    end else begin
      cls = CL_ILLEGAL;
    end
    return cls;
  endfunction

  // Illegal codes behave like idle; a mode drop overrides every other transition.
  function automatic state_e fsm_next(input state_e cur, input code_class_e cls,
                                      input logic same, input logic hit, input logic en);
    state_e nx;
    if (!en || (cls == CL_IDLE) || (cls == CL_ILLEGAL)) begin
      nx = ST_IDLE;
    end else begin
      case (cur)
        ST_IDLE: begin
          if (hit) begin
            nx = ST_SOLVED;
          end else if (cls == CL_IDX) begin
            nx = ST_TRACK;
          end else begin
            nx = ST_IDLE;
          end
        end
        ST_TRACK: begin
          if (hit) begin
            nx = ST_SOLVED;
          end else begin
            nx = ST_TRACK;
          end
        end
        ST_SOLVED: begin
          if (!same) begin
            nx = ST_TRACK;
          end else begin
            nx = ST_SOLVED;
          end
        end
        default: nx = ST_IDLE;
      endcase
    end
    return nx;
  endfunction

endpackage

// File: rtl/change_decoder_blink_divider.sv
// Blink half-period divider: counts 0..BLINK_DIV-1 while running and toggles phase on wrap.
module change_decoder_blink_divider
  import change_decoder_pkg::*;
#(
  parameter int BLINK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic run,
  output logic phase
);

  localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          phase_r;

  // Restart parks the divider at count 0 with the LED phase on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r   <= {CW{1'b0}};
      phase_r <= 1'b1;
    end else if (restart) begin
      cnt_r   <= {CW{1'b0}};
      phase_r <= 1'b1;
    end else if (run) begin
      if (cnt_r == LAST) begin
        cnt_r   <= {CW{1'b0}};
        phase_r <= ~phase_r;
      end else begin
        cnt_r   <= cnt_r + CW'(1);
        phase_r <= phase_r;
      end
    end else begin
      cnt_r   <= cnt_r;
      phase_r <= phase_r;
    end
  end

  assign phase = phase_r;

endmodule

// File: rtl/change_decoder.sv
// Change-hint receiver: turns comparator codes into a blinking one-hot LED hint.
// Define CHANGE_DECODER_ERR_EN to add the sticky illegal-code flag on port err.
module change_decoder
  import change_decoder_pkg::*;
#(
  parameter int NUM_BITS     = HINT_BITS,
  parameter int BLINK_DIV    = 4,
  parameter int SOLVE_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          change,
  input  logic                advance,
  input  logic                practicle,
  output logic [NUM_BITS-1:0] led,
  output logic                hint_valid,
  output logic [3:0]          hint_index,
  output logic [CNT_W-1:0]    step_count,
  output logic                solved
`ifdef CHANGE_DECODER_ERR_EN
  ,
  output logic                err
`endif
);

  localparam int RUN_W = $clog2(SOLVE_CYCLES);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(SOLVE_CYCLES - 1);

  logic [3:0]          code_r;
  logic [3:0]          prev_r;
  logic [3:0]          hint_index_r;
  logic [RUN_W-1:0]    run_len_r;
  logic [RUN_W-1:0]    run_nx_s;
  logic [CNT_W-1:0]    step_r;
  logic [CNT_W-1:0]    step_inc_s;
  logic [NUM_BITS-1:0] led_r;
  logic [NUM_BITS-1:0] hint_led_s;
  state_e              state_r;
  state_e              state_nx_s;
  code_class_e         cls_s;
  logic                en_s;
  logic                same_s;
  logic                solve_hit_s;
  logic                new_hint_s;
  logic                phase_s;
  logic                div_restart_s;
  logic                div_run_s;
  logic                hint_valid_r;
  logic                solved_r;

  // Decode the registered code; a code equal to last cycle's means the board matches.
  always_comb begin
    en_s   = advance | practicle;
    cls_s  = classify(code_r, NUM_BITS);
    same_s = (code_r == prev_r);
    if (!same_s) begin
      run_nx_s = {RUN_W{1'b0}};
    end else if (run_len_r == RUN_MAX) begin
      run_nx_s = RUN_MAX;
    end else begin
      run_nx_s = run_len_r + RUN_W'(1);
    end
    solve_hit_s = (run_nx_s == RUN_MAX);
    new_hint_s  = (cls_s == CL_IDX) && ((state_r == ST_IDLE) || (code_r != hint_index_r));
    if (&step_r) begin
      step_inc_s = step_r;
    end else begin
      step_inc_s = step_r + CNT_W'(1);
    end
    state_nx_s    = fsm_next(state_r, cls_s, same_s, solve_hit_s, en_s);
    hint_led_s    = NUM_BITS'(1) << hint_index_r;
    div_run_s     = (state_r == ST_TRACK);
    div_restart_s = (state_r != ST_TRACK);
  end

  change_decoder_blink_divider #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk     (clk),
    .reset   (reset),
    .restart (div_restart_s),
    .run     (div_run_s),
    .phase   (phase_s)
  );

  // FSM, hint latch, step counter and LED drive; LEDs follow the state one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_r       <= CODE_IDLE;
      prev_r       <= CODE_IDLE;
      state_r      <= ST_IDLE;
      run_len_r    <= {RUN_W{1'b0}};
      hint_index_r <= 4'd0;
      step_r       <= {CNT_W{1'b0}};
      led_r        <= {NUM_BITS{1'b0}};
      hint_valid_r <= 1'b0;
      solved_r     <= 1'b0;
    end else begin
      code_r       <= change;
      prev_r       <= code_r;
      state_r      <= state_nx_s;
      hint_valid_r <= (state_nx_s == ST_TRACK);
      solved_r     <= (state_nx_s == ST_SOLVED);
      if (!en_s) begin
        run_len_r    <= {RUN_W{1'b0}};
        step_r       <= {CNT_W{1'b0}};
        led_r        <= {NUM_BITS{1'b0}};
        hint_index_r <= hint_index_r;
      end else begin
        run_len_r <= run_nx_s;
        if (new_hint_s) begin
          hint_index_r <= code_r;
          step_r       <= step_inc_s;
        end else begin
          hint_index_r <= hint_index_r;
          step_r       <= step_r;
        end
        case (state_r)
          ST_TRACK:  led_r <= hint_led_s & {NUM_BITS{phase_s}};
          ST_SOLVED: led_r <= {NUM_BITS{1'b1}};
          default:   led_r <= {NUM_BITS{1'b0}};
        endcase
      end
    end
  end

  assign led        = led_r;
  assign hint_valid = hint_valid_r;
  assign hint_index = hint_index_r;
  assign step_count = step_r;
  assign solved     = solved_r;

`ifdef CHANGE_DECODER_ERR_EN
  logic err_r;

  // Sticky: only reset clears it, a mode drop does not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if (en_s && (cls_s == CL_ILLEGAL)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`endif

endmodule

// File: tb/tb_change_decoder.sv
// Randomized self-checking bench for change_decoder against a cycle-level behavioural model.
module tb_change_decoder;

  localparam int NUM_BITS     = 10;
  localparam int BLINK_DIV    = 4;
  localparam int SOLVE_CYCLES = 4;
  localparam int CNT_W        = 8;
  localparam int STEP_MAX     = 255;

  logic                clk = 1'b0;
  logic                reset;
  logic [3:0]          change;
  logic                advance;
  logic                practicle;
  logic [NUM_BITS-1:0] led;
  logic                hint_valid;
  logic [3:0]          hint_index;
  logic [CNT_W-1:0]    step_count;
  logic                solved;
`ifdef CHANGE_DECODER_ERR_EN
  logic                err;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  int                  m_code;
  int                  m_prev;
  int                  m_run;
  int                  m_hint;
  int                  m_steps;
  int                  m_tcyc;
  bit                  m_trk;
  bit                  m_sol;
  bit                  m_err;
  logic [NUM_BITS-1:0] m_led;

  change_decoder #(
    .NUM_BITS     (NUM_BITS),
    .BLINK_DIV    (BLINK_DIV),
    .SOLVE_CYCLES (SOLVE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .change     (change),
    .advance    (advance),
    .practicle  (practicle),
    .led        (led),
    .hint_valid (hint_valid),
    .hint_index (hint_index),
    .step_count (step_count),
    .solved     (solved)
`ifdef CHANGE_DECODER_ERR_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_code  = 14;
    m_prev  = 14;
    m_run   = 0;
    m_hint  = 0;
    m_steps = 0;
    m_tcyc  = 0;
    m_trk   = 1'b0;
    m_sol   = 1'b0;
    m_err   = 1'b0;
    m_led   = '0;
  endtask

  // One rising edge of the reference behaviour, using the inputs present at that edge.
  task automatic model_step();
    bit en, idx, blnk, idl, ill, stable, n_trk, n_sol;
    int n_run;
    if (!reset) begin
      model_reset();
      return;
    end
    en     = advance | practicle;
    idx    = (m_code < NUM_BITS);
    blnk   = (m_code == 15);
    idl    = !idx && !blnk;
    ill    = idl && (m_code != 14);
    stable = (m_code == m_prev);
    n_run  = (en && stable) ? ((m_run + 1 > SOLVE_CYCLES - 1) ? SOLVE_CYCLES - 1 : m_run + 1) : 0;
    m_led = '0;
    if (en && m_trk) begin
      if (((m_tcyc / BLINK_DIV) % 2) == 0) m_led[m_hint] = 1'b1;
    end else if (en && m_sol) begin
      m_led = '1;
    end
    if (m_trk) m_tcyc++;
    if (en && idx && ((!m_trk && !m_sol) || (m_code != m_hint))) begin
      m_hint  = m_code;
      m_steps = (m_steps == STEP_MAX) ? STEP_MAX : m_steps + 1;
    end
    if (!en) m_steps = 0;
    if (en && ill) m_err = 1'b1;
    if (!en || idl) begin
      n_trk = 1'b0; n_sol = 1'b0;
    end else if (n_run == SOLVE_CYCLES - 1) begin
      n_trk = 1'b0; n_sol = 1'b1;
    end else if (m_sol) begin
      n_trk = !stable; n_sol = stable;
    end else if (m_trk || idx) begin
      n_trk = 1'b1; n_sol = 1'b0;
    end else begin
      n_trk = 1'b0; n_sol = 1'b0;
    end
    if (n_trk && !m_trk) m_tcyc = 0;
    m_trk  = n_trk;
    m_sol  = n_sol;
    m_run  = n_run;
    m_prev = m_code;
    m_code = int'(change);
  endtask

  task automatic check_all();
    check_eq("led", 32'(led), 32'(m_led));
    check_eq("hint_valid", 32'(hint_valid), 32'(m_trk));
    check_eq("hint_index", 32'(hint_index), 32'(m_hint));
    check_eq("step_count", 32'(step_count), 32'(m_steps));
    check_eq("solved", 32'(solved), 32'(m_sol));
`ifdef CHANGE_DECODER_ERR_EN
    check_eq("err", 32'(err), 32'(m_err));
`endif
  endtask

  task automatic cycle(input logic [3:0] c, input logic a, input logic p);
    change    = c;
    advance   = a;
    practicle = p;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [3:0] seq [6];
    logic [3:0] c;
    logic [3:0] last;
    logic       a, p;
    int         r;

    reset = 1'b1; change = 4'd3; advance = 1'b1; practicle = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    #1 check_all();
    repeat (3) cycle(4'd3, 1'b1, 1'b1);
    reset = 1'b1;
    repeat (3) cycle(4'd3, 1'b0, 1'b0);
    check_eq("idle_until_en", 32'(hint_valid), 32'd0);

    // Alternating index/blink keeps the hint tracking with a blinking LED.
    for (int i = 0; i < 24; i++) cycle((i % 2 == 0) ? 4'd3 : 4'hF, 1'b0, 1'b1);
    check_eq("alt_hint", 32'(hint_index), 32'd3);
    check_eq("alt_steps", 32'(step_count), 32'd1);

    cycle(4'hF, 1'b0, 1'b0);
    check_eq("drop_led", 32'(led), 32'd0);
    check_eq("drop_steps", 32'(step_count), 32'd0);
    check_eq("drop_valid", 32'(hint_valid), 32'd0);
    cycle(4'hE, 1'b0, 1'b0);

    seq = '{4'd3, 4'hF, 4'd5, 4'hF, 4'd5, 4'hF};
    for (int i = 0; i < 6; i++) cycle(seq[i], 1'b1, 1'b0);
    check_eq("seq_steps", 32'(step_count), 32'd2);
    check_eq("seq_hint", 32'(hint_index), 32'd5);
    repeat (8) cycle(4'd5, 1'b1, 1'b0);
    check_eq("solve_flag", 32'(solved), 32'd1);
    check_eq("solve_led", 32'(led), 32'h3FF);

    // Asynchronous reset while solved must clear outputs before the next edge.
    reset = 1'b0;
    #1;
    check_eq("arst_solved", 32'(solved), 32'd0);
    check_eq("arst_led", 32'(led), 32'd0);
    check_eq("arst_steps", 32'(step_count), 32'd0);
    model_reset();
    cycle(4'd5, 1'b1, 1'b1);
    reset = 1'b1;

    cycle(4'd2, 1'b1, 1'b0);
    cycle(4'hF, 1'b1, 1'b0);
    cycle(4'hB, 1'b1, 1'b0);
    cycle(4'hE, 1'b1, 1'b0);
    check_eq("ill_valid", 32'(hint_valid), 32'd0);
    cycle(4'hE, 1'b1, 1'b0);
    check_eq("ill_led", 32'(led), 32'd0);
`ifdef CHANGE_DECODER_ERR_EN
    check_eq("err_set", 32'(err), 32'd1);
    for (int i = 0; i < 10; i++) cycle((i % 2 == 0) ? 4'd7 : 4'hF, 1'b0, 1'b0);
    check_eq("err_sticky", 32'(err), 32'd1);
`endif

    last = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4) c = 4'($urandom_range(0, 15));
      else if (r < 7) c = last;
      else if (r < 9) c = 4'hF;
      else c = 4'hE;
      if ($urandom_range(0, 19) == 0) begin
        a = 1'b0; p = 1'b0;
      end else begin
        a = 1'($urandom_range(0, 1));
        p = a ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      last = c;
      cycle(c, a, p);
    end

    for (int i = 0; i < 600; i++) cycle((i % 2 == 0) ? 4'd1 : 4'd2, 1'b1, 1'b1);
    check_eq("sat_steps", 32'(step_count), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
